// File: rtl/bp_pkg.sv
// Types shared by the TAGE predictor integration and its update scheduler.
package bp_pkg;

  typedef struct packed {
    logic [31:0] pc;
    logic        pred;
    logic        actual;
    logic [31:0] target;
  } bp_upd_t;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2,
    WAIT  = 2'd3
  } sched_state_t;

endpackage

// File: rtl/bp_upd_fifo.sv
// Dual-write, single-read circular buffer of resolved branches; slot 1 alone
// lands at the write pointer so the queue stays dense.
module bp_upd_fifo
  import bp_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PW    = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          wr0_en_i,
  input  bp_upd_t       wr0_data_i,
  input  logic          wr1_en_i,
  input  bp_upd_t       wr1_data_i,
  input  logic          pop_i,
  output bp_upd_t       head_o,
  output logic [PW:0]   count_o
);

  bp_upd_t       mem_q [DEPTH];
  logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d, wb_idx;
  logic [PW:0]   count_q, count_d;
  logic          wa_en, wb_en;
  bp_upd_t       wa_data;

  always_comb begin
    wa_en   = wr0_en_i | wr1_en_i;
    wa_data = wr0_en_i ? wr0_data_i : wr1_data_i;
    wb_en   = wr0_en_i & wr1_en_i;
    wb_idx  = wptr_q + PW'(1);
    wptr_d  = wptr_q + PW'(wa_en) + PW'(wb_en);
    rptr_d  = rptr_q + PW'(pop_i);
    count_d = count_q + (PW+1)'(wa_en) + (PW+1)'(wb_en) - (PW+1)'(pop_i);
  end

  // Storage carries no reset; only pointers and occupancy are control state.
  always_ff @(posedge clk_i) begin
    if (wa_en) mem_q[wptr_q] <= wa_data;
    if (wb_en) mem_q[wb_idx] <= wr1_data_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  assign head_o  = mem_q[rptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/bp_update_sched.sv
// Serialises two-wide branch commit onto the predictor's single update port,
// with a drain handshake and saturating update/mispredict statistics.
module bp_update_sched
  import bp_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmt0_valid,
  input  logic [31:0]      cmt0_pc,
  input  logic             cmt0_pred,
  input  logic             cmt0_actual,
  input  logic [31:0]      cmt0_target,
  input  logic             cmt1_valid,
  input  logic [31:0]      cmt1_pc,
  input  logic             cmt1_pred,
  input  logic             cmt1_actual,
  input  logic [31:0]      cmt1_target,
  output logic             cmt_ready,
  input  logic             upd_hold,
  input  logic             drain_req,
  output logic             drain_done,
  output logic             update_valid,
  output logic [31:0]      update_pc,
  output logic             update_prediction,
  output logic             update_actual,
  output logic [31:0]      update_target,
  input  logic             stat_clr,
  output logic [CNT_W-1:0] stat_updates,
  output logic [CNT_W-1:0] stat_mispred
);

  localparam int PW = $clog2(DEPTH);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  sched_state_t     state_q;
  logic             drain_done_q;
  logic [PW:0]      count, free_slots;
  bp_upd_t          head, in0, in1;
  logic             pop, mispred;
  logic [CNT_W-1:0] stat_upd_q, stat_upd_d, stat_mis_q, stat_mis_d;

  assign in0 = '{pc: cmt0_pc, pred: cmt0_pred, actual: cmt0_actual, target: cmt0_target};
  assign in1 = '{pc: cmt1_pc, pred: cmt1_pred, actual: cmt1_actual, target: cmt1_target};

  // Credit comes only from registered occupancy; a pop this cycle is ignored.
  assign free_slots = (PW+1)'(DEPTH) - count;
  assign cmt_ready  = (state_q == RUN) && (free_slots >= (PW+1)'(2));

  bp_upd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i      (clk),
    .rst_ni     (rst),
    .wr0_en_i   (cmt_ready & cmt0_valid),
    .wr0_data_i (in0),
    .wr1_en_i   (cmt_ready & cmt1_valid),
    .wr1_data_i (in1),
    .pop_i      (pop),
    .head_o     (head),
    .count_o    (count)
  );

  assign pop     = (count != '0) && !upd_hold;
  assign mispred = head.pred ^ head.actual;

  always_comb begin
    update_valid      = pop;
    update_pc         = pop ? head.pc     : '0;
    update_prediction = pop & head.pred;
    update_actual     = pop & head.actual;
    update_target     = pop ? head.target : '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= RUN;
      drain_done_q <= 1'b0;
    end else begin
      drain_done_q <= 1'b0;
      case (state_q)
        RUN:   if (drain_req) state_q <= DRAIN;
        DRAIN: if ((count == '0) || ((count == (PW+1)'(1)) && pop)) begin
                 state_q      <= DONE;
                 drain_done_q <= 1'b1;
               end
        DONE:  state_q <= drain_req ? WAIT : RUN;
        WAIT:  if (!drain_req) state_q <= RUN;
        default: state_q <= RUN;
      endcase
    end
  end

  assign drain_done = drain_done_q;

  always_comb begin
    stat_upd_d = stat_upd_q;
    stat_mis_d = stat_mis_q;
    if (stat_clr) begin
      stat_upd_d = '0;
      stat_mis_d = '0;
    end else if (pop) begin
      stat_upd_d = sat_inc(stat_upd_q);
      if (mispred) stat_mis_d = sat_inc(stat_mis_q);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_upd_q <= '0;
      stat_mis_q <= '0;
    end else begin
      stat_upd_q <= stat_upd_d;
      stat_mis_q <= stat_mis_d;
    end
  end

  assign stat_updates = stat_upd_q;
  assign stat_mispred = stat_mis_q;

endmodule

// File: tb/tb_bp_update_sched.sv
// Directed bench for bp_update_sched: ordering, full/wrap, drain, stats, reset.
module tb_bp_update_sched;

  localparam int DEPTH = 4;
  localparam int CW    = 4;
  localparam logic [CW-1:0] MAXV = '1;

  logic          clk, rst;
  logic          cmt0_valid, cmt0_pred, cmt0_actual;
  logic [31:0]   cmt0_pc, cmt0_target;
  logic          cmt1_valid, cmt1_pred, cmt1_actual;
  logic [31:0]   cmt1_pc, cmt1_target;
  logic          cmt_ready, upd_hold, drain_req, drain_done;
  logic          update_valid, update_prediction, update_actual;
  logic [31:0]   update_pc, update_target;
  logic          stat_clr;
  logic [CW-1:0] stat_updates, stat_mispred;

  bp_update_sched #(.DEPTH(DEPTH), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .cmt0_valid(cmt0_valid), .cmt0_pc(cmt0_pc), .cmt0_pred(cmt0_pred),
    .cmt0_actual(cmt0_actual), .cmt0_target(cmt0_target),
    .cmt1_valid(cmt1_valid), .cmt1_pc(cmt1_pc), .cmt1_pred(cmt1_pred),
    .cmt1_actual(cmt1_actual), .cmt1_target(cmt1_target),
    .cmt_ready(cmt_ready), .upd_hold(upd_hold), .drain_req(drain_req),
    .drain_done(drain_done), .update_valid(update_valid), .update_pc(update_pc),
    .update_prediction(update_prediction), .update_actual(update_actual),
    .update_target(update_target), .stat_clr(stat_clr),
    .stat_updates(stat_updates), .stat_mispred(stat_mispred)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int done_seen = 0;
  logic [31:0] lpc[$];
  logic [31:0] ltgt[$];
  logic        lpred[$];
  logic        lact[$];
  int          lcyc[$];

  always @(posedge clk) cyc++;

  // Observation log of every issued update, sampled mid-cycle.
  always @(negedge clk) begin
    if (update_valid) begin
      lpc.push_back(update_pc);
      ltgt.push_back(update_target);
      lpred.push_back(update_prediction);
      lact.push_back(update_actual);
      lcyc.push_back(cyc);
    end
    if (drain_done) done_seen++;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Branch attributes are derived from the PC: pred=~pc[4], actual=pc[5], target=pc+0x100.
  task automatic push(input bit v0, input logic [31:0] p0, input bit v1, input logic [31:0] p1);
    int w;
    w = 0;
    while (!cmt_ready && w < 20) begin
      tick(1);
      w++;
    end
    if (!cmt_ready) begin
      checks++;
      failures++;
      $display("FAIL push_ready_timeout cmt_ready=%0b want 1", cmt_ready);
    end
    cmt0_valid = v0; cmt0_pc = p0; cmt0_pred = ~p0[4]; cmt0_actual = p0[5]; cmt0_target = p0 + 32'h100;
    cmt1_valid = v1; cmt1_pc = p1; cmt1_pred = ~p1[4]; cmt1_actual = p1[5]; cmt1_target = p1 + 32'h100;
    tick(1);
    cmt0_valid = 1'b0;
    cmt1_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    cmt0_valid = 0; cmt0_pc = 0; cmt0_pred = 0; cmt0_actual = 0; cmt0_target = 0;
    cmt1_valid = 0; cmt1_pc = 0; cmt1_pred = 0; cmt1_actual = 0; cmt1_target = 0;
    upd_hold = 0; drain_req = 0; stat_clr = 0;
    tick(2);
    checks++; if (update_valid !== 1'b0) begin failures++; $display("FAIL rst_update_valid got=%0b want=0", update_valid); end
    checks++; if (update_pc !== 32'h0) begin failures++; $display("FAIL rst_update_pc got=%h want=0", update_pc); end
    checks++; if (drain_done !== 1'b0) begin failures++; $display("FAIL rst_drain_done got=%0b want=0", drain_done); end
    checks++; if (stat_updates !== '0 || stat_mispred !== '0) begin failures++; $display("FAIL rst_stats got=%h/%h want=0/0", stat_updates, stat_mispred); end
    rst = 1'b1;
    #1;
    checks++; if (cmt_ready !== 1'b1) begin failures++; $display("FAIL rst_cmt_ready got=%0b want=1", cmt_ready); end
    tick(1);
  endtask

  task automatic test_single;
    int n0;
    n0 = lpc.size();
    push(1, 32'h100, 0, 32'h0);
    tick(4);
    checks++; if (lpc.size() - n0 !== 1) begin failures++; $display("FAIL single_count got=%0d want=1", lpc.size() - n0); end
    if (lpc.size() > n0) begin
      checks++; if (lpc[n0] !== 32'h100) begin failures++; $display("FAIL single_pc got=%h want=100", lpc[n0]); end
      checks++; if (lact[n0] !== 1'b0 || lpred[n0] !== 1'b1) begin failures++; $display("FAIL single_dir got=%0b/%0b want=1/0", lpred[n0], lact[n0]); end
      checks++; if (ltgt[n0] !== 32'h200) begin failures++; $display("FAIL single_tgt got=%h want=200", ltgt[n0]); end
    end
    checks++; if (stat_updates !== CW'(1)) begin failures++; $display("FAIL single_stat_upd got=%h want=1", stat_updates); end
    checks++; if (stat_mispred !== CW'(1)) begin failures++; $display("FAIL single_stat_mis got=%h want=1", stat_mispred); end
  endtask

  task automatic test_dual;
    int n0;
    n0 = lpc.size();
    push(1, 32'h10, 1, 32'h20);
    tick(4);
    checks++; if (lpc.size() - n0 !== 2) begin failures++; $display("FAIL dual_count got=%0d want=2", lpc.size() - n0); end
    if (lpc.size() >= n0 + 2) begin
      checks++; if (lpc[n0] !== 32'h10 || lpc[n0+1] !== 32'h20) begin failures++; $display("FAIL dual_order got=%h,%h want=10,20", lpc[n0], lpc[n0+1]); end
      checks++; if (lcyc[n0+1] - lcyc[n0] !== 1) begin failures++; $display("FAIL dual_consecutive gap=%0d want=1", lcyc[n0+1] - lcyc[n0]); end
    end
    n0 = lpc.size();
    push(0, 32'h0, 1, 32'h30);
    tick(4);
    checks++; if (lpc.size() - n0 !== 1) begin failures++; $display("FAIL slot1_count got=%0d want=1", lpc.size() - n0); end
    if (lpc.size() > n0) begin
      checks++; if (lpc[n0] !== 32'h30) begin failures++; $display("FAIL slot1_pc got=%h want=30", lpc[n0]); end
    end
  endtask

  task automatic test_full_wrap;
    int n0;
    logic [31:0] exp4 [4];
    logic [31:0] exp6 [6];
    exp4 = '{32'h40, 32'h50, 32'h60, 32'h70};
    exp6 = '{32'h80, 32'h90, 32'ha0, 32'hb0, 32'hc0, 32'hd0};
    n0 = lpc.size();
    upd_hold = 1'b1;
    push(1, 32'h40, 1, 32'h50);
    checks++; if (cmt_ready !== 1'b1) begin failures++; $display("FAIL full_half_ready got=%0b want=1", cmt_ready); end
    push(1, 32'h60, 1, 32'h70);
    checks++; if (cmt_ready !== 1'b0) begin failures++; $display("FAIL full_ready got=%0b want=0", cmt_ready); end
    checks++; if (update_valid !== 1'b0) begin failures++; $display("FAIL full_hold_valid got=%0b want=0", update_valid); end
    upd_hold = 1'b0;
    #1;
    checks++; if (update_valid !== 1'b1 || cmt_ready !== 1'b0) begin failures++; $display("FAIL full_pop_no_credit valid=%0b ready=%0b want 1/0", update_valid, cmt_ready); end
    tick(6);
    checks++; if (lpc.size() - n0 !== 4) begin failures++; $display("FAIL full_count got=%0d want=4", lpc.size() - n0); end
    for (int i = 0; i < 4; i++) begin
      if (lpc.size() > n0 + i) begin
        checks++; if (lpc[n0+i] !== exp4[i]) begin failures++; $display("FAIL full_order[%0d] got=%h want=%h", i, lpc[n0+i], exp4[i]); end
      end
    end
    if (lpc.size() >= n0 + 4) begin
      checks++; if (lcyc[n0+3] - lcyc[n0] !== 3) begin failures++; $display("FAIL full_throughput span=%0d want=3", lcyc[n0+3] - lcyc[n0]); end
    end
    n0 = lpc.size();
    push(1, 32'h80, 1, 32'h90);
    push(1, 32'ha0, 1, 32'hb0);
    push(1, 32'hc0, 1, 32'hd0);
    tick(8);
    checks++; if (lpc.size() - n0 !== 6) begin failures++; $display("FAIL wrap_count got=%0d want=6", lpc.size() - n0); end
    for (int i = 0; i < 6; i++) begin
      if (lpc.size() > n0 + i) begin
        checks++; if (lpc[n0+i] !== exp6[i]) begin failures++; $display("FAIL wrap_order[%0d] got=%h want=%h", i, lpc[n0+i], exp6[i]); end
      end
    end
  endtask

  task automatic test_drain;
    int n0, d0, w;
    n0 = lpc.size();
    upd_hold = 1'b1;
    push(1, 32'h300, 1, 32'h310);
    push(1, 32'h320, 0, 32'h0);
    d0 = done_seen;
    drain_req = 1'b1;
    upd_hold = 1'b0;
    tick(1);
    checks++; if (cmt_ready !== 1'b0) begin failures++; $display("FAIL drain_ready got=%0b want=0", cmt_ready); end
    w = 0;
    while (!drain_done && w < 20) begin
      tick(1);
      w++;
    end
    checks++; if (drain_done !== 1'b1) begin failures++; $display("FAIL drain_done_timeout got=%0b want=1", drain_done); end
    checks++; if (lpc.size() - n0 !== 3) begin failures++; $display("FAIL drain_count got=%0d want=3", lpc.size() - n0); end
    if (lpc.size() >= n0 + 3) begin
      checks++; if (lpc[n0] !== 32'h300 || lpc[n0+1] !== 32'h310 || lpc[n0+2] !== 32'h320) begin
        failures++; $display("FAIL drain_order got=%h,%h,%h want=300,310,320", lpc[n0], lpc[n0+1], lpc[n0+2]);
      end
    end
    tick(3);
    checks++; if (done_seen - d0 !== 1) begin failures++; $display("FAIL drain_single_pulse got=%0d want=1", done_seen - d0); end
    checks++; if (cmt_ready !== 1'b0) begin failures++; $display("FAIL drain_wait_ready got=%0b want=0", cmt_ready); end
    drain_req = 1'b0;
    tick(1);
    checks++; if (cmt_ready !== 1'b1) begin failures++; $display("FAIL drain_release_ready got=%0b want=1", cmt_ready); end
    drain_req = 1'b1;
    tick(1);
    checks++; if (drain_done !== 1'b0) begin failures++; $display("FAIL empty_drain_early got=%0b want=0", drain_done); end
    tick(1);
    checks++; if (drain_done !== 1'b1) begin failures++; $display("FAIL empty_drain_done got=%0b want=1", drain_done); end
    drain_req = 1'b0;
    tick(1);
    checks++; if (drain_done !== 1'b0 || cmt_ready !== 1'b1) begin failures++; $display("FAIL empty_drain_back done=%0b ready=%0b want 0/1", drain_done, cmt_ready); end
  endtask

  task automatic test_stats;
    logic [CW-1:0] em;
    logic [31:0]   pc;
    stat_clr = 1'b1;
    tick(1);
    stat_clr = 1'b0;
    checks++; if (stat_updates !== '0 || stat_mispred !== '0) begin failures++; $display("FAIL stat_clr got=%h/%h want=0/0", stat_updates, stat_mispred); end
    em = '0;
    for (int i = 0; i < 17; i++) begin
      pc = 32'h1000 + 32'(i) * 32'h10;
      if (pc[4] == pc[5] && em != MAXV) em = em + 1'b1;
    end
    for (int i = 0; i < 14; i += 2) push(1, 32'h1000 + 32'(i) * 32'h10, 1, 32'h1000 + 32'(i + 1) * 32'h10);
    tick(8);
    checks++; if (stat_updates !== 4'hE) begin failures++; $display("FAIL stat_preload got=%h want=e", stat_updates); end
    push(1, 32'h10e0, 1, 32'h10f0);
    push(1, 32'h1100, 0, 32'h0);
    tick(8);
    checks++; if (stat_updates !== MAXV) begin failures++; $display("FAIL stat_saturate got=%h want=%h", stat_updates, MAXV); end
    checks++; if (stat_mispred !== em) begin failures++; $display("FAIL stat_mispred got=%h want=%h", stat_mispred, em); end
    push(1, 32'h2000, 0, 32'h0);
    checks++; if (update_valid !== 1'b1) begin failures++; $display("FAIL stat_clr_issue_valid got=%0b want=1", update_valid); end
    stat_clr = 1'b1;
    tick(1);
    stat_clr = 1'b0;
    checks++; if (stat_updates !== '0 || stat_mispred !== '0) begin failures++; $display("FAIL stat_clr_priority got=%h/%h want=0/0", stat_updates, stat_mispred); end
    push(1, 32'h2010, 0, 32'h0);
    tick(2);
    checks++; if (stat_updates !== CW'(1) || stat_mispred !== '0) begin failures++; $display("FAIL stat_after_clr got=%h/%h want=1/0", stat_updates, stat_mispred); end
  endtask

  task automatic test_async_reset;
    int n0, d0;
    upd_hold = 1'b1;
    push(1, 32'h3000, 1, 32'h3010);
    drain_req = 1'b1;
    tick(2);
    checks++; if (drain_done !== 1'b0 || cmt_ready !== 1'b0) begin failures++; $display("FAIL ar_in_drain done=%0b ready=%0b want 0/0", drain_done, cmt_ready); end
    n0 = lpc.size();
    d0 = done_seen;
    upd_hold = 1'b0;
    #1;
    checks++; if (update_valid !== 1'b1) begin failures++; $display("FAIL ar_pre_valid got=%0b want=1", update_valid); end
    #1;
    rst = 1'b0;
    #1;
    checks++; if (update_valid !== 1'b0 || update_pc !== 32'h0) begin failures++; $display("FAIL ar_immediate valid=%0b pc=%h want 0/0", update_valid, update_pc); end
    drain_req = 1'b0;
    tick(2);
    #2;
    rst = 1'b1;
    tick(1);
    checks++; if (cmt_ready !== 1'b1 || update_valid !== 1'b0) begin failures++; $display("FAIL ar_run_empty ready=%0b valid=%0b want 1/0", cmt_ready, update_valid); end
    tick(3);
    checks++; if (done_seen - d0 !== 0) begin failures++; $display("FAIL ar_no_pulse got=%0d want=0", done_seen - d0); end
    checks++; if (lpc.size() - n0 !== 0) begin failures++; $display("FAIL ar_no_issue got=%0d want=0", lpc.size() - n0); end
    checks++; if (stat_updates !== '0) begin failures++; $display("FAIL ar_stats got=%h want=0", stat_updates); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_dual();
    test_full_wrap();
    test_drain();
    test_stats();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
